clk_en_sched: RTL and testbench
===============================

Name: clk_en_sched

Overview:
- Synchronous clock-enable generator and shared-multiplier scheduler for the synth core.
- Produces single-cycle enable strobes on one system clock at the modulation, sample, 2x-sample, ADSR and multiplier rates.
- Arbitrates the single shared multiplier between NREQ datapath requesters (envelope, filter, mixer, ...), one grant per multiplier slot, round-robin.

Parameters:
MULT_DIV_LOG2, 5, log2 of the multiplier-slot period in clk cycles
SAMPLE_DIV_LOG2, 9, log2 of the sample period; the 2x-sample period is 2^(SAMPLE_DIV_LOG2-1)
ADSR_DIV_LOG2, 18, log2 of the ADSR period; also the counter width
NREQ, 4, number of multiplier requesters (2..8)

Ports:
clk  in  1  system clock; all logic on the rising edge
rstn  in  1  reset, synchronous, active-low
run  in  1  1 = counter advances; 0 = freeze
req  in  NREQ  multiplier request, one bit per requester, level
done  in  1  granted requester finished; one-cycle pulse
en_sample  out  1  sample-rate strobe
en_sample_x2  out  1  2x-sample-rate strobe
en_adsr  out  1  ADSR-rate strobe
en_mult  out  1  multiplier-slot strobe
gnt  out  NREQ  one-hot grant
gnt_valid  out  1  OR of gnt
gnt_id  out  3  binary index of the granted requester
overrun  out  1  sticky: a slot tick arrived while a grant was still active
clr_overrun  in  1  clears overrun

Behaviour:
- Reset (rstn=0 at an edge): cnt=0, all strobes 0, gnt=0, gnt_valid=0, gnt_id=0, overrun=0, state=IDLE, last=NREQ-1 (requester 0 has first priority).
- Counter: cnt is ADSR_DIV_LOG2 bits. It increments by 1 per edge while run=1 and wraps from all-ones to 0. It holds while run=0.
- Internal tick_K is defined as run && cnt[K-1:0]=={K{1}}.
  - Each strobe is a register: en_X <= tick_K for its rate.
  - Result: each strobe is one cycle wide, period 2^K with run held at 1.
  - The first en_mult is high in the cycle after the 32nd counting edge following reset release.
- Alignment: every en_sample coincides with an en_sample_x2 and an en_mult. Every en_adsr coincides with en_sample. With run=0, all strobes are 0 from the next edge.
- Arbiter states:
  - IDLE: on the edge where tick_mult=1 and |req:
    - Grant the first requester with req=1 searching last+1, last+2, ... modulo NREQ.
    - Register gnt one-hot, gnt_id, gnt_valid=1; go to GRANT.
    - gnt rises in the same cycle as en_mult.
    - With no req, stay IDLE.
  - GRANT: on done=1, gnt/gnt_valid go to 0 at that edge; last=gnt_id; state IDLE.
    - gnt_id holds its value after release.
    - A new grant is issued only at the next tick_mult. done and tick_mult on the same edge: release first, no grant until the following tick.
- done in IDLE: ignored.
- req dropped while granted: grant is held until done.
- Overrun: tick_mult while in GRANT (and done=0) sets overrun. clr_overrun=1 clears it; set and clear on the same edge: set wins.
- run=0 while in GRANT: done still releases the grant. No new grants occur because tick_mult stays 0.
- rstn mid-grant: everything returns to reset values at that edge.

Optional Feature:
- Macro: MULT_TIMEOUT_EN
- Defined: a tick_mult while in GRANT (done=0) sets overrun and forcibly revokes the grant at that edge. last becomes the revoked gnt_id and state returns to IDLE. That tick does not issue a grant; the next tick arbitrates normally.
- Not defined: the grant is held indefinitely until done; overrun is only flagged.

Test Plan:
- Reset release with run=1, no req: en_mult period 32, en_sample_x2 period 256, en_sample period 512 (coincides with en_mult), first en_mult after 32 edges; gnt stays 0.
- req=4'b1111, done pulsed 3 cycles after each grant: gnt_id sequence 0,1,2,3,0 on consecutive en_mult slots; overrun stays 0.
- req=4'b0100 only, done never pulsed: gnt=4'b0100 persists, overrun=1 at the next tick. With MULT_TIMEOUT_EN, gnt=0 from that tick and regranted to 2 one slot later.
- run=0 for 100 cycles mid-period (cnt=10): strobes 0; after run=1, en_mult occurs 22 counting edges later. done during the freeze releases an active grant.
- Simultaneous set/clear: clr_overrun=1 on the edge an overrun tick occurs -> overrun=1. clr_overrun alone -> 0.
- rstn=0 for one edge while gnt=4'b0010: all outputs 0 next cycle. Next grant with req=4'b0011 goes to requester 0.

Source files
------------

// File: rtl/clk_en_sched.sv
// rtl/clk_en_sched.sv - rate strobes and round-robin scheduler for the shared multiplier
// Build option MULT_TIMEOUT_EN: an overdue grant is revoked at the next multiplier slot.
module clk_en_sched #(
   parameter int MULT_DIV_LOG2   = 5,
   parameter int SAMPLE_DIV_LOG2 = 9,
   parameter int ADSR_DIV_LOG2   = 18,
   parameter int NREQ            = 4
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            run,
   input  logic [NREQ-1:0] req,
   input  logic            done,
   input  logic            clr_overrun,
   output logic            en_sample,
   output logic            en_sample_x2,
   output logic            en_adsr,
   output logic            en_mult,
   output logic [NREQ-1:0] gnt,
   output logic            gnt_valid,
   output logic [2:0]      gnt_id,
   output logic            overrun
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                   state_q, state_d;
   logic [ADSR_DIV_LOG2-1:0] cnt_q, cnt_d;
   logic                     en_sample_q, en_x2_q, en_adsr_q, en_mult_q;
   logic [NREQ-1:0]          gnt_q, gnt_d;
   logic                     gnt_valid_q, gnt_valid_d;
   logic [2:0]               gnt_id_q, gnt_id_d;
   logic [2:0]               last_q, last_d;
   logic                     overrun_q, overrun_d;
   logic                     ovr_set;

   logic                     tick_mult, tick_x2, tick_sample, tick_adsr;
   logic [7:0]               req_ext;
   logic                     pick_found;
   logic [2:0]               pick_id;

   // Every rate divides the ADSR period, so all ticks come from one free-running counter.
   assign tick_mult   = run & (&cnt_q[MULT_DIV_LOG2-1:0]);
   assign tick_x2     = run & (&cnt_q[SAMPLE_DIV_LOG2-2:0]);
   assign tick_sample = run & (&cnt_q[SAMPLE_DIV_LOG2-1:0]);
   assign tick_adsr   = run & (&cnt_q);

   assign cnt_d = run ? cnt_q + {{(ADSR_DIV_LOG2-1){1'b0}}, 1'b1} : cnt_q;

   // Search starts just after the last released requester.
   always_comb begin
      req_ext    = 8'(req);
      pick_found = 1'b0;
      pick_id    = '0;
      for (int i = 1; i <= NREQ; i++) begin
         if (!pick_found && req_ext[3'((int'(last_q) + i) % NREQ)]) begin
            pick_found = 1'b1;
            pick_id    = 3'((int'(last_q) + i) % NREQ);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gnt_valid_d = gnt_valid_q;
      gnt_id_d    = gnt_id_q;
      last_d      = last_q;
      ovr_set     = 1'b0;
      case (state_q)
         IDLE: begin
            if (tick_mult && pick_found) begin
               state_d     = GRANT;
               gnt_d       = NREQ'(8'd1 << pick_id);
               gnt_valid_d = 1'b1;
               gnt_id_d    = pick_id;
            end
         end
         GRANT: begin
            if (done) begin
               state_d     = IDLE;
               gnt_d       = '0;
               gnt_valid_d = 1'b0;
               last_d      = gnt_id_q;
            end else if (tick_mult) begin
               ovr_set = 1'b1;
`ifdef MULT_TIMEOUT_EN
               state_d     = IDLE;
               gnt_d       = '0;
               gnt_valid_d = 1'b0;
               last_d      = gnt_id_q;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
      overrun_d = ovr_set | (overrun_q & ~clr_overrun);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         en_sample_q <= 1'b0;
         en_x2_q     <= 1'b0;
         en_adsr_q   <= 1'b0;
         en_mult_q   <= 1'b0;
         gnt_q       <= '0;
         gnt_valid_q <= 1'b0;
         gnt_id_q    <= '0;
         last_q      <= 3'(NREQ - 1);
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         en_sample_q <= tick_sample;
         en_x2_q     <= tick_x2;
         en_adsr_q   <= tick_adsr;
         en_mult_q   <= tick_mult;
         gnt_q       <= gnt_d;
         gnt_valid_q <= gnt_valid_d;
         gnt_id_q    <= gnt_id_d;
         last_q      <= last_d;
         overrun_q   <= overrun_d;
      end
   end

   assign en_sample    = en_sample_q;
   assign en_sample_x2 = en_x2_q;
   assign en_adsr      = en_adsr_q;
   assign en_mult      = en_mult_q;
   assign gnt          = gnt_q;
   assign gnt_valid    = gnt_valid_q;
   assign gnt_id       = gnt_id_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_clk_en_sched.sv
// tb/tb_clk_en_sched.sv - directed and random checks of clk_en_sched against a cycle reference model
module tb_clk_en_sched;

   localparam int MDL  = 5;
   localparam int SDL  = 9;
   localparam int ADL  = 18;
   localparam int NREQ = 4;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic            run = 1'b0;
   logic [NREQ-1:0] req = '0;
   logic            done = 1'b0;
   logic            clr_overrun = 1'b0;
   logic            en_sample, en_sample_x2, en_adsr, en_mult;
   logic [NREQ-1:0] gnt;
   logic            gnt_valid;
   logic [2:0]      gnt_id;
   logic            overrun;

   int errors = 0;
   int checks = 0;

   int m_cnt, m_owner, m_id, m_last;
   bit m_en_s, m_en_x2, m_en_a, m_en_m, m_ovr;

   clk_en_sched #(
      .MULT_DIV_LOG2(MDL), .SAMPLE_DIV_LOG2(SDL), .ADSR_DIV_LOG2(ADL), .NREQ(NREQ)
   ) dut (
      .clk(clk), .rstn(rstn), .run(run), .req(req), .done(done),
      .clr_overrun(clr_overrun), .en_sample(en_sample), .en_sample_x2(en_sample_x2),
      .en_adsr(en_adsr), .en_mult(en_mult), .gnt(gnt), .gnt_valid(gnt_valid),
      .gnt_id(gnt_id), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // A rate of period 2^k fires on the edge that completes a full period of counting.
   function automatic bit tick_at(int k);
      return run && (((m_cnt + 1) % (1 << k)) == 0);
   endfunction

   task automatic model_edge();
      bit tm, set;
      if (!rstn) begin
         m_cnt = 0; m_en_s = 0; m_en_x2 = 0; m_en_a = 0; m_en_m = 0;
         m_owner = -1; m_id = 0; m_last = NREQ - 1; m_ovr = 0;
         return;
      end
      tm      = tick_at(MDL);
      m_en_m  = tm;
      m_en_x2 = tick_at(SDL - 1);
      m_en_s  = tick_at(SDL);
      m_en_a  = tick_at(ADL);
      set     = 0;
      if (m_owner >= 0) begin
         if (done) begin
            m_last = m_owner; m_owner = -1;
         end else if (tm) begin
            set = 1;
`ifdef MULT_TIMEOUT_EN
            m_last = m_owner; m_owner = -1;
`endif
         end
      end else if (tm && req != 0) begin
         for (int i = 1; i <= NREQ; i++) begin
            if (req[(m_last + i) % NREQ]) begin
               m_owner = (m_last + i) % NREQ;
               m_id    = m_owner;
               break;
            end
         end
      end
      if (set) m_ovr = 1;
      else if (clr_overrun) m_ovr = 0;
      if (run) m_cnt = (m_cnt + 1) % (1 << ADL);
   endtask

   task automatic check_all();
      chk("en_mult", en_mult, m_en_m);
      chk("en_sample", en_sample, m_en_s);
      chk("en_sample_x2", en_sample_x2, m_en_x2);
      chk("en_adsr", en_adsr, m_en_a);
      chk("gnt", gnt, (m_owner >= 0) ? (1 << m_owner) : 0);
      chk("gnt_valid", gnt_valid, m_owner >= 0);
      chk("gnt_id", gnt_id, m_id);
      chk("overrun", overrun, m_ovr);
   endtask

   task automatic step(input logic r, input logic [NREQ-1:0] rq, input logic d,
                       input logic c, input logic rs);
      run = r; req = rq; done = d; clr_overrun = c; rstn = rs;
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   int first_m, first_x2, first_s, n, since, cnt_edges;
   int ids[5];
   bit prev_v;
   int exp_ids[5] = '{0, 1, 2, 3, 0};

   initial begin
      // reset, then free-run with no requests
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      first_m = 0; first_x2 = 0; first_s = 0;
      for (int k = 1; k <= 520; k++) begin
         step(1, 0, 0, 0, 1);
         if (en_mult && first_m == 0) first_m = k;
         if (en_sample_x2 && first_x2 == 0) first_x2 = k;
         if (en_sample && first_s == 0) begin
            first_s = k;
            chk("sample_with_mult", en_mult, 1);
            chk("sample_with_x2", en_sample_x2, 1);
         end
      end
      chk("first_en_mult", first_m, 32);
      chk("first_en_x2", first_x2, 256);
      chk("first_en_sample", first_s, 512);

      // all requesting: round-robin order
      ids = '{-1, -1, -1, -1, -1};
      n = 0; since = 0; prev_v = 0;
      for (int k = 0; k < 250 && n < 5; k++) begin
         step(1, 4'hF, since == 3, 0, 1);
         if (gnt_valid && !prev_v) ids[n++] = gnt_id;
         prev_v = gnt_valid;
         since  = gnt_valid ? since + 1 : 0;
      end
      for (int i = 0; i < 5; i++) chk("rr_order", ids[i], exp_ids[i]);
      chk("rr_no_overrun", overrun, 0);

      // requester 2 holds the multiplier without finishing
      step(1, 4'b0100, 1, 0, 1);
      for (int k = 0; k < 40 && !gnt_valid; k++) step(1, 4'b0100, 0, 0, 1);
      chk("hold_gnt", gnt, 4'b0100);
      repeat (32) step(1, 4'b0100, 0, 0, 1);
      chk("overrun_set", overrun, 1);
`ifdef MULT_TIMEOUT_EN
      chk("revoked", gnt, 4'b0000);
`else
      chk("still_held", gnt, 4'b0100);
`endif
      repeat (32) step(1, 4'b0100, 0, 0, 1);
      chk("gnt_after_2slots", gnt, 4'b0100);

      // clear alone, then clear colliding with a set
      step(1, 4'b0100, 0, 1, 1);
      chk("ovr_clr", overrun, 0);
      for (int k = 0; k < 100 && !(((m_cnt + 1) % 32 == 0) && m_owner >= 0); k++)
         step(1, 4'b0100, 0, 0, 1);
      step(1, 4'b0100, 0, 1, 1);
      chk("ovr_set_wins", overrun, 1);
      step(1, 4'b0100, 0, 1, 1);
      chk("ovr_clr2", overrun, 0);

      // freeze mid-period with an active grant
      step(1, 4'b0100, 1, 0, 1);
      for (int k = 0; k < 40 && !gnt_valid; k++) step(1, 4'b0100, 0, 0, 1);
      for (int k = 0; k < 40 && (m_cnt % 32) != 10; k++) step(1, 4'b0100, 0, 0, 1);
      chk("freeze_cnt10", m_cnt % 32, 10);
      for (int k = 0; k < 100; k++) step(0, 4'b0100, k == 50, 0, 1);
      chk("freeze_released", gnt_valid, 0);
      chk("freeze_no_mult", en_mult, 0);
      cnt_edges = 0;
      for (int k = 1; k <= 40 && cnt_edges == 0; k++) begin
         step(1, 0, 0, 0, 1);
         if (en_mult) cnt_edges = k;
      end
      chk("resume_mult", cnt_edges, 22);

      // reset in the middle of a grant
      for (int k = 0; k < 40 && !gnt_valid; k++) step(1, 4'b0010, 0, 0, 1);
      chk("pre_reset_gnt", gnt, 4'b0010);
      step(1, 4'b0010, 0, 0, 0);
      chk("rst_gnt", gnt, 0);
      chk("rst_valid", gnt_valid, 0);
      chk("rst_id", gnt_id, 0);
      for (int k = 0; k < 40 && !gnt_valid; k++) step(1, 4'b0011, 0, 0, 1);
      chk("post_reset_first", gnt_id, 0);
      chk("post_reset_gnt", gnt, 4'b0001);

      // random traffic
      for (int k = 0; k < 2000; k++)
         step($urandom_range(0, 9) != 0, NREQ'($urandom_range(0, 15)),
              $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 299) != 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
